// File: rtl/hazard_pkg.sv
// Shared encodings and instruction field positions for the hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2
  } state_e;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_reg_cmp.sv
// Compares one producer destination against the ID instruction's rs/rt sources.
module hazard_reg_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] dest_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic                  uses_rt_i,
  output logic                  hit_o
);

  logic dest_live;
  logic rs_hit;
  logic rt_hit;

  // $zero is hardwired, so a write to it never creates a dependency.
  always_comb begin
    dest_live = (dest_i != REG_ADDR_W'(REG_ZERO));
    rs_hit    = dest_live && (dest_i == rs_i);
    rt_hit    = dest_live && uses_rt_i && (dest_i == rt_i);
    hit_o     = rs_hit || rt_hit;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-in-ID hazard detection with multi-cycle bubbles and memory freeze.
// Optional per-cause cycle counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INST_W-1:0]     if_id_inst_i,
  input  logic                  id_uses_rt_i,
  input  logic                  id_is_branch_i,
  input  logic                  id_ex_memrd_i,
  input  logic                  id_ex_regwrite_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  ex_mem_memrd_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_stall_i,
  output logic                  pc_stall_o,
  output logic                  stallHold_o,
  output logic                  mux_control_o,
  output logic                  if_id_flush_o,
  output logic                  pipe_freeze_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      lu_stall_cnt_o,
  output logic [CNT_W-1:0]      br_stall_cnt_o,
  output logic [CNT_W-1:0]      freeze_cnt_o
`endif
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic                  ex_hit;
  logic                  mem_hit;
  logic                  lu;
  logic                  bd;
  logic                  unused_inst;

  assign rs          = if_id_inst_i[RS_MSB:RS_LSB];
  assign rt          = if_id_inst_i[RT_MSB:RT_LSB];
  assign unused_inst = ^{if_id_inst_i[INST_W-1:RS_MSB+1], if_id_inst_i[RT_LSB-1:0]};

  hazard_reg_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_cmp_ex (
    .dest_i    (id_ex_rd_i),
    .rs_i      (rs),
    .rt_i      (rt),
    .uses_rt_i (id_uses_rt_i),
    .hit_o     (ex_hit)
  );

  hazard_reg_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_cmp_mem (
    .dest_i    (ex_mem_rd_i),
    .rs_i      (rs),
    .rt_i      (rt),
    .uses_rt_i (id_uses_rt_i),
    .hit_o     (mem_hit)
  );

  assign lu = id_ex_memrd_i && ex_hit;
  assign bd = id_is_branch_i && ((id_ex_regwrite_i && ex_hit) || (ex_mem_memrd_i && mem_hit));

  state_e     state_q, state_d;
  state_e     ret_state_q, ret_state_d;
  state_e     eff_state;
  logic [2:0] bub_cnt_q, bub_cnt_d;
  logic       flush_pend_q, flush_pend_d;
  logic       stall;
  logic       flush;
  logic       freeze;

  always_comb begin
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    bub_cnt_d    = bub_cnt_q;
    flush_pend_d = flush_pend_q;
    stall        = 1'b0;
    flush        = 1'b0;
    freeze       = 1'b0;
    // Once the memory releases, the interrupted state's behaviour applies in that same cycle.
    eff_state    = (state_q == StMemWait) ? ret_state_q : state_q;

    if (mem_stall_i) begin
      freeze       = 1'b1;
      state_d      = StMemWait;
      ret_state_d  = eff_state;
      flush_pend_d = flush_pend_q | branch_taken_i;
    end else begin
      case (eff_state)
        StLuStall: begin
          stall        = 1'b1;
          bub_cnt_d    = bub_cnt_q - 3'd1;
          flush_pend_d = flush_pend_q | branch_taken_i;
          state_d      = (bub_cnt_q == 3'd1) ? StRun : StLuStall;
        end
        default: begin
          state_d = StRun;
          if (lu || bd) begin
            stall        = 1'b1;
            flush_pend_d = flush_pend_q | branch_taken_i;
            if (lu && (LOAD_LAT > 1)) begin
              state_d   = StLuStall;
              bub_cnt_d = LAT_M1;
            end
          end else begin
            flush        = branch_taken_i | flush_pend_q;
            flush_pend_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StRun;
      ret_state_q  <= StRun;
      bub_cnt_q    <= 3'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_state_q  <= ret_state_d;
      bub_cnt_q    <= bub_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, not just at the edge.
  assign pc_stall_o    = rst_i & stall;
  assign stallHold_o   = rst_i & stall;
  assign mux_control_o = rst_i & stall;
  assign if_id_flush_o = rst_i & flush;
  assign pipe_freeze_o = rst_i & freeze;

`ifdef HAZ_PERF_CNT_EN
  logic             lu_cyc;
  logic             br_cyc;
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] frz_cnt_q;

  assign lu_cyc = stall && ((eff_state == StLuStall) || lu);
  assign br_cyc = stall && !lu_cyc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lu_cnt_q  <= '0;
      br_cnt_q  <= '0;
      frz_cnt_q <= '0;
    end else begin
      if (lu_cyc && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 1'b1;
      if (br_cyc && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 1'b1;
      if (freeze && (frz_cnt_q != '1)) frz_cnt_q <= frz_cnt_q + 1'b1;
    end
  end

  assign lu_stall_cnt_o = lu_cnt_q;
  assign br_stall_cnt_o = br_cnt_q;
  assign freeze_cnt_o   = frz_cnt_q;
`else
  // Counters are not built; the stall behaviour above is unchanged.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed bench for hazard_stall_ctrl at LOAD_LAT = 1 and LOAD_LAT = 3.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] inst;
  logic        uses_rt, is_branch, ex_memrd, ex_regwrite, mem_memrd, br_taken, mem_stall;
  logic [4:0]  ex_rd, mem_rd;

  logic pc1, hold1, mux1, flush1, frz1;
  logic pc3, hold3, mux3, flush3, frz3;
  logic [4:0] vec1, vec3;

  assign vec1 = {pc1, hold1, mux1, flush1, frz1};
  assign vec3 = {pc3, hold3, mux3, flush3, frz3};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .if_id_inst_i(inst), .id_uses_rt_i(uses_rt),
    .id_is_branch_i(is_branch), .id_ex_memrd_i(ex_memrd), .id_ex_regwrite_i(ex_regwrite),
    .id_ex_rd_i(ex_rd), .ex_mem_memrd_i(mem_memrd), .ex_mem_rd_i(mem_rd),
    .branch_taken_i(br_taken), .mem_stall_i(mem_stall), .pc_stall_o(pc1),
    .stallHold_o(hold1), .mux_control_o(mux1), .if_id_flush_o(flush1), .pipe_freeze_o(frz1)
  );

  hazard_stall_ctrl #(.LOAD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_i), .if_id_inst_i(inst), .id_uses_rt_i(uses_rt),
    .id_is_branch_i(is_branch), .id_ex_memrd_i(ex_memrd), .id_ex_regwrite_i(ex_regwrite),
    .id_ex_rd_i(ex_rd), .ex_mem_memrd_i(mem_memrd), .ex_mem_rd_i(mem_rd),
    .branch_taken_i(br_taken), .mem_stall_i(mem_stall), .pc_stall_o(pc3),
    .stallHold_o(hold3), .mux_control_o(mux3), .if_id_flush_o(flush3), .pipe_freeze_o(frz3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit track    = 1'b0;
  int frz_n    = 0;
  int stl_n    = 0;

  // Reference: bubbles still owed, and whether a taken branch is waiting to flush.
  int lat[2]  = '{1, 3};
  int bub[2]  = '{0, 0};
  bit pend[2] = '{1'b0, 1'b0};

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic bit hit(input logic [4:0] d);
    logic [4:0] rs, rt;
    rs = inst[25:21];
    rt = inst[20:16];
    return (d != 0) && ((d == rs) || (uses_rt && (d == rt)));
  endfunction

  function automatic bit m_lu();
    return ex_memrd && hit(ex_rd);
  endfunction

  function automatic bit m_bd();
    return is_branch && ((ex_regwrite && hit(ex_rd)) || (mem_memrd && hit(mem_rd)));
  endfunction

  // Output order: {pc_stall, stallHold, mux_control, if_id_flush, pipe_freeze}.
  function automatic logic [4:0] m_expect(input int k);
    if (mem_stall) return 5'b00001;
    if (bub[k] > 0 || m_lu() || m_bd()) return 5'b11100;
    return {3'b000, br_taken | pend[k], 1'b0};
  endfunction

  task automatic m_advance();
    for (int k = 0; k < 2; k++) begin
      if (mem_stall) begin
        pend[k] = pend[k] | br_taken;
      end else if (bub[k] > 0) begin
        bub[k]--;
        pend[k] = pend[k] | br_taken;
      end else if (m_lu() || m_bd()) begin
        if (m_lu()) bub[k] = lat[k] - 1;
        pend[k] = pend[k] | br_taken;
      end else begin
        pend[k] = 1'b0;
      end
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      bub[k]  = 0;
      pend[k] = 1'b0;
    end
  endtask

  task automatic step();
    logic [4:0] e1, e3;
    e1 = m_expect(0);
    e3 = m_expect(1);
    @(negedge clk);
    check_eq($sformatf("lat1_cyc%0d", cyc), vec1, e1);
    check_eq($sformatf("lat3_cyc%0d", cyc), vec3, e3);
    if (track) begin
      if (frz3) frz_n++;
      if (pc3) stl_n++;
    end
    @(posedge clk);
    m_advance();
    cyc++;
    #1;
  endtask

  task automatic idle();
    inst = 32'h0; uses_rt = 0; is_branch = 0; ex_memrd = 0; ex_regwrite = 0;
    ex_rd = 0; mem_memrd = 0; mem_rd = 0; br_taken = 0; mem_stall = 0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 16'h0020};
  endfunction

  task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urt);
    idle();
    inst = mk(rs, rt); uses_rt = urt; ex_memrd = 1; ex_regwrite = 1; ex_rd = rd;
  endtask

  // Called at posedge+1; asserts reset mid-cycle with hazard inputs still applied.
  task automatic async_reset(input string tag);
    #3;
    rst_i = 1'b0;
    #1;
    check_eq({tag, "_lat1"}, vec1, 5'b00000);
    check_eq({tag, "_lat3"}, vec3, 5'b00000);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    m_reset();
  endtask

  initial begin
    rst_i = 1'b0;
    set_lu(5'd2, 5'd4, 5'd2, 1'b1);
    #1;
    check_eq("rst_init_lat1", vec1, 5'b00000);
    check_eq("rst_init_lat3", vec3, 5'b00000);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    idle();
    step();

    // lw $2 ; add $3,$2,$4
    set_lu(5'd2, 5'd4, 5'd2, 1'b1); step();
    idle(); repeat (3) step();
    // Destination $zero never stalls
    set_lu(5'd0, 5'd4, 5'd0, 1'b1); step();
    idle(); step();
    // Load-use through rt
    set_lu(5'd7, 5'd2, 5'd2, 1'b1); step();
    idle(); repeat (3) step();
    // rt-only match while rt is not a source
    set_lu(5'd7, 5'd2, 5'd2, 1'b0); step();
    idle(); step();

    // beq $5,$6 behind an ALU write of $5
    idle(); inst = mk(5'd5, 5'd6); uses_rt = 1; is_branch = 1; ex_regwrite = 1; ex_rd = 5'd5;
    step(); idle(); step();
    // beq $5,$6 behind a load of $6 in MEM
    idle(); inst = mk(5'd5, 5'd6); uses_rt = 1; is_branch = 1; mem_memrd = 1; mem_rd = 5'd6;
    step(); idle(); step();
    // Non-matching producers
    idle(); inst = mk(5'd5, 5'd6); uses_rt = 1; is_branch = 1; ex_regwrite = 1; ex_rd = 5'd9;
    mem_memrd = 1; mem_rd = 5'd10;
    step(); idle(); step();

    // Freeze arriving in the middle of a 3-bubble load-use stall
    set_lu(5'd7, 5'd2, 5'd2, 1'b1); step();
    idle(); mem_stall = 1; track = 1'b1;
    repeat (4) step();
    mem_stall = 0;
    repeat (3) step();
    track = 1'b0;
    check_eq("frz_cycles", 5'(frz_n), 5'd4);
    check_eq("stall_after_frz", 5'(stl_n), 5'd2);

    // Taken branch during a freeze is deferred until the pipeline runs again
    idle(); mem_stall = 1; step();
    br_taken = 1; step();
    br_taken = 0; step();
    mem_stall = 0; step();
    step();

    // Reset in the middle of LU_STALL
    set_lu(5'd2, 5'd4, 5'd2, 1'b1); step();
    async_reset("rst_lu");
    idle(); step(); step();

    // Reset in the middle of MEM_WAIT with a pending flush
    idle(); mem_stall = 1; br_taken = 1; step();
    br_taken = 0; step();
    async_reset("rst_mw");
    idle(); step(); step();

    for (int i = 0; i < 600; i++) begin
      uses_rt     = 1'($urandom_range(0, 1));
      inst        = {6'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      is_branch   = ($urandom_range(0, 3) == 0);
      ex_memrd    = ($urandom_range(0, 2) == 0);
      ex_regwrite = ex_memrd | ($urandom_range(0, 1) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      mem_memrd   = ($urandom_range(0, 2) == 0);
      mem_rd      = 5'($urandom_range(0, 3));
      br_taken    = ($urandom_range(0, 5) == 0);
      mem_stall   = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 149) == 0) async_reset($sformatf("rst_rand%0d", i));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised hazard detection and stall controller for the 5-stage MIPS pipeline, sitting between the IF/ID, ID/EX and EX/MEM registers and the PC.
- Extends plain load-use detection in four ways:
  - multi-cycle load-use bubbles (LOAD_LAT);
  - branch-in-ID data hazards;
  - whole-pipeline freeze on data-memory stall;
  - pending-flush capture across a freeze.
- Sequential state (FSM plus bubble counter) tracks stalls that outlive the combinational detection window.

Parameters:
REG_ADDR_W, 5, register-file address width
INST_W, 32, instruction width; rs at [25:21], rt at [20:16]
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7); 1 gives classic single bubble
CNT_W, 16, width of performance counters (only with HAZ_PERF_CNT_EN)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
if_id_inst_i  input  INST_W  instruction in ID
id_uses_rt_i  input  1  ID instruction reads rt as a source (R-type, beq, sw)
id_is_branch_i  input  1  ID instruction is a branch resolved in ID
id_ex_memrd_i  input  1  EX instruction is a load
id_ex_regwrite_i  input  1  EX instruction writes a register
id_ex_rd_i  input  REG_ADDR_W  EX destination, after RegDst mux
ex_mem_memrd_i  input  1  MEM instruction is a load
ex_mem_rd_i  input  REG_ADDR_W  MEM destination
branch_taken_i  input  1  single-cycle pulse: branch taken
mem_stall_i  input  1  data memory busy, level
pc_stall_o  output  1  hold PC
stallHold_o  output  1  hold IF/ID
mux_control_o  output  1  zero control into ID/EX (bubble)
if_id_flush_o  output  1  flush IF/ID
pipe_freeze_o  output  1  hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB

Behaviour:
- Detection terms (combinational; a destination of 0 never matches):
  - rs_hit(d) = (d == rs) && d != 0
  - rt_hit(d) = id_uses_rt_i && (d == rt) && d != 0
  - lu = id_ex_memrd_i && (rs_hit(id_ex_rd_i) || rt_hit(id_ex_rd_i))
  - bd = id_is_branch_i && ((id_ex_regwrite_i && hit on id_ex_rd_i) || (ex_mem_memrd_i && hit on ex_mem_rd_i))
- States: RUN, LU_STALL, MEM_WAIT. Registers: state, bub_cnt[2:0], ret_state, flush_pend.
- Reset (rst_i low, async): state = RUN, bub_cnt = 0, flush_pend = 0. All outputs read 0 while rst_i is low.
- Priority: mem_stall_i > (lu | bd) > flush.
- RUN:
  - mem_stall_i = 1 → pipe_freeze_o = 1; next state MEM_WAIT; ret_state = RUN.
  - Else lu | bd → pc_stall_o = stallHold_o = mux_control_o = 1 in the same cycle.
    - lu with LOAD_LAT > 1 → next state LU_STALL, bub_cnt = LOAD_LAT-1.
  - Else if_id_flush_o = branch_taken_i | flush_pend; flush_pend cleared.
- LU_STALL:
  - All three stall outputs = 1; bub_cnt decrements each cycle.
  - bub_cnt == 1 → next state RUN.
  - mem_stall_i = 1 → MEM_WAIT with ret_state = LU_STALL; bub_cnt is held, not decremented.
- MEM_WAIT:
  - pipe_freeze_o = mem_stall_i. Other stall outputs are 0; the freeze dominates.
  - mem_stall_i falls → return to ret_state in the same cycle and resume that state's outputs.
  - branch_taken_i during the freeze sets flush_pend. The flush is issued on the first RUN cycle without a hazard.
- Latency: detection outputs are combinational (0 cycles). State changes take effect on the next rising edge.
- Stall outputs must never assert together with if_id_flush_o; stall wins and the flush is deferred via flush_pend.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Adds outputs lu_stall_cnt_o, br_stall_cnt_o and freeze_cnt_o, each CNT_W wide.
  - Each counts cycles spent in its stall cause and saturates at all-ones.
  - Reset to 0 by rst_i.
- HAZ_PERF_CNT_EN undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - the state encoding (RUN = 0, LU_STALL = 1, MEM_WAIT = 2);
  - RS_MSB/RS_LSB/RT_MSB/RT_LSB field constants;
  - the REG_ZERO constant.
- Sub-module hazard_reg_cmp: a one-destination-vs-rs/rt comparator with zero skip and rt enable. It is instantiated twice (EX and MEM destinations).

Test Plan:
- LOAD_LAT = 1:
  - lw $2 in EX (id_ex_memrd_i = 1, id_ex_rd_i = 2), ID = add $3,$2,$4 → stall outputs = 1 for exactly 1 cycle, state stays RUN.
  - Same with id_ex_rd_i = 0 → no stall.
- LOAD_LAT = 3, load-use on rt with id_uses_rt_i = 1 → stall outputs high for 3 consecutive cycles, then 0.
  - Repeat with id_uses_rt_i = 0 and a rt-only match → no stall.
- Branch-in-ID cases:
  - beq $5,$6 with id_ex_regwrite_i = 1, id_ex_rd_i = 5 → 1-cycle stall.
  - With ex_mem_memrd_i = 1, ex_mem_rd_i = 6 → stall.
  - Non-matching registers → no stall.
- LOAD_LAT = 3, mem_stall_i asserted for 4 cycles starting in the 2nd LU_STALL cycle → pipe_freeze_o high for 4 cycles, then exactly 2 more stall cycles.
- branch_taken_i pulse during a freeze → if_id_flush_o = 0 while frozen, then 1 for one cycle on the first RUN cycle after mem_stall_i falls.
- rst_i driven low mid-LU_STALL and mid-MEM_WAIT → all outputs 0 immediately (asynchronously); after release, state RUN and flush_pend clear. With HAZ_PERF_CNT_EN, all counters read 0.
